// File: rtl/serial_alu_seq.sv
// Bit-serial add/subtract using one external full-adder slice; DONE pulses WIDTH cycles after START is accepted.
// START is sampled only in IDLE and ignored while BUSY or DONE is high, with no queueing.
module serial_alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             COUT,
    output logic             OVF,
    output logic             ZERO,
    output logic             FA_A,
    output logic             FA_B,
    output logic             FA_CIN,
    input  logic             FA_S,
    input  logic             FA_COUT
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] areg_q;
    logic [WIDTH-1:0] breg_q;
    logic [WIDTH-1:0] rreg_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // Partial sum including the bit the adder is producing this cycle.
    logic [WIDTH-1:0] sum_d;
    assign sum_d = {FA_S, rreg_q[WIDTH-1:1]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            areg_q   <= '0;
            breg_q   <= '0;
            rreg_q   <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        areg_q  <= A;
                        breg_q  <= SUB ? ~B : B;
                        carry_q <= SUB;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    areg_q  <= areg_q >> 1;
                    breg_q  <= breg_q >> 1;
                    rreg_q  <= sum_d;
                    carry_q <= FA_COUT;
                    if (cnt_q == LAST) begin
                        cnt_q    <= '0;
                        result_q <= sum_d;
                        cout_q   <= FA_COUT;
                        // Operand MSBs have been shifted down to bit 0 by now.
                        ovf_q    <= (areg_q[0] == breg_q[0]) && (FA_S != areg_q[0]);
                        zero_q   <= (sum_d == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // busy_q is high exactly in RUN, so the adder inputs idle at 0 elsewhere.
    assign FA_A   = busy_q & areg_q[0];
    assign FA_B   = busy_q & breg_q[0];
    assign FA_CIN = busy_q & carry_q;

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;
    assign COUT   = cout_q;
    assign OVF    = ovf_q;
    assign ZERO   = zero_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed test of serial_alu_seq with a behavioural full-adder slice.
module tb_serial_alu_seq;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        SUB = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        BUSY, DONE, COUT, OVF, ZERO;
    logic [15:0] RESULT;
    logic        FA_A, FA_B, FA_CIN, FA_S, FA_COUT;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    assign {FA_COUT, FA_S} = {1'b0, FA_A} + {1'b0, FA_B} + {1'b0, FA_CIN};

    serial_alu_seq #(.WIDTH(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .COUT(COUT), .OVF(OVF), .ZERO(ZERO),
        .FA_A(FA_A), .FA_B(FA_B), .FA_CIN(FA_CIN), .FA_S(FA_S), .FA_COUT(FA_COUT)
    );

    // Issues one request and watches 30 cycles; lat = cycles from accepting edge to DONE.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         output int lat, output int busy_n, output int done_n, output logic cin1);
        lat = -1; busy_n = 0; done_n = 0; cin1 = 1'b0;
        @(negedge CLK);
        A = a; B = b; SUB = sub; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cin1 = FA_CIN;
        for (int n = 1; n <= 30; n++) begin
            if (n > 1) @(negedge CLK);
            if (BUSY) busy_n++;
            if (DONE) begin
                done_n++;
                if (lat < 0) lat = n - 1;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b, expected 00", {BUSY, DONE}); end
        n_cmp++; if (RESULT !== 16'h0000) begin n_bad++; $display("FAIL reset_result: got %h, expected 0000", RESULT); end
        n_cmp++; if ({COUT, OVF, ZERO} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b, expected 000", {COUT, OVF, ZERO}); end
        n_cmp++; if ({FA_A, FA_B, FA_CIN} !== 3'b000) begin n_bad++; $display("FAIL reset_fa: got %b, expected 000", {FA_A, FA_B, FA_CIN}); end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_add;
        int lat, bn, dn;
        logic c1;
        do_op(16'h1234, 16'h4321, 1'b0, lat, bn, dn, c1);
        n_cmp++; if (RESULT !== 16'h5555) begin n_bad++; $display("FAIL add_result: got %h, expected 5555", RESULT); end
        n_cmp++; if ({COUT, OVF, ZERO} !== 3'b000) begin n_bad++; $display("FAIL add_flags: got %b, expected 000", {COUT, OVF, ZERO}); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL add_latency: got %0d, expected 16", lat); end
        n_cmp++; if (bn !== 16) begin n_bad++; $display("FAIL add_busy_cycles: got %0d, expected 16", bn); end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL add_done_pulses: got %0d, expected 1", dn); end
        n_cmp++; if (c1 !== 1'b0) begin n_bad++; $display("FAIL add_first_cin: got %b, expected 0", c1); end
        n_cmp++; if ({FA_A, FA_B, FA_CIN} !== 3'b000) begin n_bad++; $display("FAIL idle_fa: got %b, expected 000", {FA_A, FA_B, FA_CIN}); end

        do_op(16'hFFFF, 16'h0001, 1'b0, lat, bn, dn, c1);
        n_cmp++; if (RESULT !== 16'h0000) begin n_bad++; $display("FAIL wrap_result: got %h, expected 0000", RESULT); end
        n_cmp++; if ({COUT, OVF, ZERO} !== 3'b101) begin n_bad++; $display("FAIL wrap_flags: got %b, expected 101", {COUT, OVF, ZERO}); end

        do_op(16'h7FFF, 16'h0001, 1'b0, lat, bn, dn, c1);
        n_cmp++; if (RESULT !== 16'h8000) begin n_bad++; $display("FAIL addovf_result: got %h, expected 8000", RESULT); end
        n_cmp++; if ({COUT, OVF, ZERO} !== 3'b010) begin n_bad++; $display("FAIL addovf_flags: got %b, expected 010", {COUT, OVF, ZERO}); end
    endtask

    task automatic test_sub;
        int lat, bn, dn;
        logic c1;
        do_op(16'h0005, 16'h0007, 1'b1, lat, bn, dn, c1);
        n_cmp++; if (RESULT !== 16'hFFFE) begin n_bad++; $display("FAIL sub_borrow_result: got %h, expected fffe", RESULT); end
        n_cmp++; if ({COUT, OVF, ZERO} !== 3'b000) begin n_bad++; $display("FAIL sub_borrow_flags: got %b, expected 000", {COUT, OVF, ZERO}); end
        n_cmp++; if (c1 !== 1'b1) begin n_bad++; $display("FAIL sub_first_cin: got %b, expected 1", c1); end

        do_op(16'h8000, 16'h0001, 1'b1, lat, bn, dn, c1);
        n_cmp++; if (RESULT !== 16'h7FFF) begin n_bad++; $display("FAIL subovf_result: got %h, expected 7fff", RESULT); end
        n_cmp++; if ({COUT, OVF, ZERO} !== 3'b110) begin n_bad++; $display("FAIL subovf_flags: got %b, expected 110", {COUT, OVF, ZERO}); end
        // Outputs must hold while idling.
        repeat (5) @(negedge CLK);
        n_cmp++; if (RESULT !== 16'h7FFF) begin n_bad++; $display("FAIL idle_hold: got %h, expected 7fff", RESULT); end
    endtask

    task automatic test_start_while_busy;
        int dn = 0;
        logic [15:0] res_at_done = '0;
        @(negedge CLK);
        A = 16'h1234; B = 16'h4321; SUB = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            if (n > 1) @(negedge CLK);
            if (n == 3) begin
                n_cmp++; if (RESULT !== 16'h7FFF) begin n_bad++; $display("FAIL run_hold: got %h, expected 7fff", RESULT); end
            end
            if (n == 5) begin A = 16'h0001; B = 16'h0001; START = 1'b1; end
            if (n == 6) START = 1'b0;
            if (DONE) begin
                dn++;
                res_at_done = RESULT;
            end
        end
        n_cmp++; if (res_at_done !== 16'h5555) begin n_bad++; $display("FAIL busy_start_result: got %h, expected 5555", res_at_done); end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL busy_start_dones: got %0d, expected 1", dn); end
    endtask

    task automatic test_reset_mid;
        int dn = 0;
        int lat, bn, dn2;
        logic c1;
        @(negedge CLK);
        A = 16'h1234; B = 16'h4321; SUB = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (7) @(negedge CLK);
        #1 RST = 1'b1;
        #1;
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b, expected 0", BUSY); end
        n_cmp++; if (RESULT !== 16'h0000) begin n_bad++; $display("FAIL midreset_result: got %h, expected 0000", RESULT); end
        #1 RST = 1'b0;
        for (int n = 0; n < 25; n++) begin
            @(negedge CLK);
            if (DONE) dn++;
        end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL midreset_done: got %0d pulses, expected 0", dn); end
        do_op(16'h0002, 16'h0003, 1'b0, lat, bn, dn2, c1);
        n_cmp++; if (RESULT !== 16'h0005) begin n_bad++; $display("FAIL post_reset_result: got %h, expected 0005", RESULT); end
        n_cmp++; if (dn2 !== 1) begin n_bad++; $display("FAIL post_reset_dones: got %0d, expected 1", dn2); end
    endtask

    task automatic test_back_to_back;
        int first = -1;
        int second = -1;
        @(negedge CLK);
        A = 16'h0100; B = 16'h0011; SUB = 1'b0; START = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLK);
            if (DONE) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        START = 1'b0;
        n_cmp++; if (RESULT !== 16'h0111) begin n_bad++; $display("FAIL b2b_result: got %h, expected 0111", RESULT); end
        n_cmp++; if (first !== 17) begin n_bad++; $display("FAIL b2b_first_done: got %0d, expected 17", first); end
        n_cmp++; if (second - first !== 18) begin n_bad++; $display("FAIL b2b_spacing: got %0d, expected 18", second - first); end
        repeat (20) @(negedge CLK);
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_start_while_busy;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
